load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator for the Data_Memory doubleword port: accepts one load/store request at a time
//  from the datapath and drives Mem_Addr/Write_Data/MemRead/MemWrite.
//  Supports RV64 byte/half/word/double accesses, sign/zero extension, and read-modify-write
//  for sub-doubleword stores. Reports misaligned/illegal requests without touching memory.
// PARAMETERS
//  ADDR_W  64  request/memory address width
//  DATA_W  64  data width; only 64 is supported
// PORTS
//  clk         in   1       single clock, all state on posedge
//  reset       in   1       synchronous, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       unit idle, request accepted when req_valid & req_ready
//  req_write   in   1       1 = store, 0 = load
//  req_funct3  in   3       000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data, right-justified
//  rsp_valid   out  1       one-cycle completion pulse, no backpressure
//  rsp_rdata   out  DATA_W  load result, extended; 0 for stores and errors
//  rsp_error   out  1       misaligned address or illegal funct3, valid with rsp_valid
//  Mem_Addr    out  ADDR_W  doubleword-aligned address: req_addr & ~7
//  Write_Data  out  DATA_W  doubleword to write
//  MemRead     out  1       read strobe; Read_Data is combinational while high
//  MemWrite    out  1       write strobe; memory writes on the posedge
//  Read_Data   in   DATA_W  doubleword from memory
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after reset deasserts; all other outputs 0. A request
//    in flight is dropped with no response. MemWrite is 0 in the cycle after reset is sampled.
//  - FSM IDLE -> {READ, WRITE, RESP}; READ -> {WRITE, RESP}; WRITE -> RESP; RESP -> IDLE.
//  - Accept in IDLE: latch write, funct3, addr, and wdata. off = addr[2:0].
//    size = 1/2/4/8 bytes from funct3[1:0].
//  - Error if funct3==111, if a store has funct3[2]==1, or if off is not a multiple of size.
//    Error path goes IDLE -> RESP with rsp_error=1, and MemRead/MemWrite stay 0.
//  - Load: READ asserts MemRead with Mem_Addr=aligned address.
//    Read_Data is captured at the end of READ.
//    lane = Read_Data >> (8*off), truncated to size, sign-extended if funct3[2]==0,
//    zero-extended otherwise. rsp_valid is high 2 cycles after accept.
//  - Store D: WRITE asserts MemWrite, Write_Data=wdata. rsp_valid is high 2 cycles after accept.
//  - Store B/H/W: READ captures the old doubleword.
//    WRITE drives old with bytes [off, off+size) replaced by wdata[8*size-1:0], little-endian.
//    rsp_valid is high 3 cycles after accept.
//  - MemRead and MemWrite are never high together. Both are 0 in IDLE and RESP.
//    Mem_Addr is 0 when both strobes are low.
//  - req_ready=0 outside IDLE; requests offered while busy are ignored, not queued.
//  - RESP: rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_error hold only in that cycle.
//  - Address bits above bit 2 pass through unchanged; no wrap-around or bounds checking.
// STRUCTURE
//  - Shared package lsu_pkg: funct3 encodings, state enum (IDLE, READ, WRITE, RESP),
//    size_from_funct3 function.
//  - One sub-module, lsu_lane_align (combinational): extract+extend for loads,
//    byte-merge for stores. The FSM and registers stay in load_store_unit.
// TESTING (bench pairs this unit with Data_Memory; clk period 10)
//  1 Reset held 2 cycles with req_valid=1: no MemRead/MemWrite; req_ready=1 after release.
//  2 SD addr 0x10, data 0x0123456789ABCDEF, then LD 0x10:
//    MemWrite 1 cycle; LD rsp_rdata=0x0123456789ABCDEF at accept+2.
//  3 After test 2, SB addr 0x13 data 0xFF: READ then WRITE of 0x01234567FFABCDEF.
//    Then LB 0x13 -> 0xFFFFFFFFFFFFFFFF, LBU 0x13 -> 0xFF.
//  4 LW 0x14 -> 0x0000000001234567; LH 0x16 -> 0x0123; SW 0x14 0x80000000 then LW 0x14
//    -> 0xFFFFFFFF80000000, LWU -> 0x80000000.
//  5 LH 0x11, SW 0x12, LD 0x08+4, funct3 111, SB with funct3 100:
//    each gives rsp_error=1 at accept+1, no strobes, memory unchanged.
//  6 Reset asserted in WRITE cycle of SB 0x18: no rsp_valid; MemWrite=0 the next cycle;
//    back-to-back requests during busy are ignored (req_ready=0).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// access-size and request-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Control fields latched at accept; the address and data live in separate registers.
    typedef struct packed {
        logic       write;
        logic [2:0] funct3;
        logic       error;
    } lsu_ctrl_t;

    function automatic logic [3:0] size_from_funct3(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    function automatic logic req_is_error(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [2:0] off);
        logic [2:0] align_mask;
        align_mask = 3'(size_from_funct3(funct3) - 4'd1);
        return (funct3 == F3_ILL) || (write && funct3[2]) || ((off & align_mask) != 3'b000);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-side request/response bundle and memory-side doubleword port bundle.
// On each interface, master is the initiating side and slave is the responding side.
interface lsu_req_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Write_Data;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] Read_Data;

    modport master (
        output Mem_Addr, Write_Data, MemRead, MemWrite,
        input  Read_Data
    );

    modport slave (
        input  Mem_Addr, Write_Data, MemRead, MemWrite,
        output Read_Data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a doubleword,
// and merges store bytes into an old doubleword (little-endian).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] dword_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] store_data_o
);

    logic [63:0] shifted;
    logic [63:0] wdata_sh;
    logic [63:0] bit_en;
    logic [7:0]  size_mask;
    logic [7:0]  byte_en;
    logic        sign_ext;

    always_comb begin
        // NOTE: every output of a combinational block is given a value before any
        // branch; a path that leaves one unassigned would infer a latch.
        load_data_o  = '0;
        store_data_o = '0;
        size_mask    = 8'hFF;
        bit_en       = '0;

        sign_ext = ~funct3_i[2];
        shifted  = dword_i >> {off_i, 3'b000};

        unique case (funct3_i[1:0])
            2'b00: begin
                load_data_o = {{56{sign_ext & shifted[7]}}, shifted[7:0]};
                size_mask   = 8'h01;
            end
            2'b01: begin
                load_data_o = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
                size_mask   = 8'h03;
            end
            2'b10: begin
                load_data_o = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
                size_mask   = 8'h0F;
            end
            default: begin
                load_data_o = shifted;
                size_mask   = 8'hFF;
            end
        endcase

        // A full doubleword enables all bytes, so the stale old value never leaks into SD.
        byte_en  = size_mask << off_i;
        wdata_sh = wdata_i << {off_i, 3'b000};
        for (int i = 0; i < 8; i++) begin
            bit_en[8*i +: 8] = {8{byte_en[i]}};
        end
        store_data_o = (dword_i & ~bit_en) | (wdata_sh & bit_en);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a doubleword memory port, with
// sub-doubleword stores done as read-modify-write and early rejection of bad requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64    // lane logic is written for 64 only
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    lsu_state_e        state_q, state_d;
    lsu_ctrl_t         ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              idle_ready;
    logic              mem_read;
    logic              mem_write;
    logic              rsp_valid;
    logic              rsp_error;
    logic [DATA_W-1:0] rsp_rdata;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_data;
    logic              accept_error;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // NOTE: address/data registers are left without reset; they are only
    // consumed in states that are reachable after a fresh accept reloads them.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        data_q  <= data_d;
    end

    assign accept_error = req_is_error(req.req_write, req.req_funct3, req.req_addr[2:0]);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        idle_ready = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_error  = 1'b0;
        rsp_rdata  = '0;

        unique case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (req.req_valid) begin
                    ctrl_d.write  = req.req_write;
                    ctrl_d.funct3 = req.req_funct3;
                    ctrl_d.error  = accept_error;
                    addr_d        = req.req_addr;
                    wdata_d       = req.req_wdata;
                    if (accept_error) begin
                        state_d = RESP;
                    end else if (req.req_write && req.req_funct3[1:0] == 2'b11) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_read = 1'b1;
                data_d   = mem.Read_Data;
                state_d  = ctrl_q.write ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_error = ctrl_q.error;
                if (!ctrl_q.write && !ctrl_q.error) begin
                    rsp_rdata = load_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .funct3_i     (ctrl_q.funct3),
        .off_i        (addr_q[2:0]),
        .dword_i      (data_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    // Ready is masked while reset is high so nothing looks accepted before release.
    assign req.req_ready = idle_ready & ~reset;
    assign req.rsp_valid = rsp_valid;
    assign req.rsp_error = rsp_error;
    assign req.rsp_rdata = rsp_rdata;

    assign mem.MemRead    = mem_read;
    assign mem.MemWrite   = mem_write;
    assign mem.Mem_Addr   = (mem_read | mem_write) ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem.Write_Data = mem_write ? store_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a small behavioural doubleword memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if #(.ADDR_W(64), .DATA_W(64)) req_if ();
    lsu_mem_if #(.ADDR_W(64), .DATA_W(64)) mem_if ();

    load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req_if),
        .mem   (mem_if)
    );

    // Data_Memory stand-in: combinational read while MemRead, write on posedge.
    logic [63:0] mem [0:31] = '{default: '0};
    assign mem_if.Read_Data = mem_if.MemRead ? mem[mem_if.Mem_Addr[7:3]] : '0;
    always @(posedge clk) begin
        if (mem_if.MemWrite) mem[mem_if.Mem_Addr[7:3]] <= mem_if.Write_Data;
    end

    int checks = 0;
    int errors = 0;

    // Observations from the most recent transaction.
    int          lat;
    int          n_rd;
    int          n_wr;
    logic        both_hi;
    logic        ready_seen;
    logic        extra_valid;
    logic [63:0] idle_addr;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] rd_addr;
    logic [63:0] w_addr;
    logic [63:0] w_data;

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d);
        @(negedge clk);
        req_if.req_valid  = 1'b1;
        req_if.req_write  = w;
        req_if.req_funct3 = f3;
        req_if.req_addr   = a;
        req_if.req_wdata  = d;
        ready_seen = req_if.req_ready;
        @(posedge clk);
        lat = -1; n_rd = 0; n_wr = 0; both_hi = 1'b0;
        r_rdata = '0; r_err = 1'b0; rd_addr = '0; w_addr = '0; w_data = '0;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) req_if.req_valid = 1'b0;
            if (mem_if.MemRead && mem_if.MemWrite) both_hi = 1'b1;
            if (mem_if.MemRead) begin
                n_rd++;
                rd_addr = mem_if.Mem_Addr;
            end
            if (mem_if.MemWrite) begin
                n_wr++;
                w_addr = mem_if.Mem_Addr;
                w_data = mem_if.Write_Data;
            end
            if (req_if.rsp_valid) begin
                lat     = k;
                r_rdata = req_if.rsp_rdata;
                r_err   = req_if.rsp_error;
            end
        end
        @(negedge clk);
        extra_valid = req_if.rsp_valid;
        idle_addr   = mem_if.Mem_Addr;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (mem_if.MemRead !== 1'b0 || mem_if.MemWrite !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobes[%0d]: MemRead=%b MemWrite=%b expected 0/0",
                         i, mem_if.MemRead, mem_if.MemWrite);
            end
            checks++;
            if (req_if.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", i, req_if.rsp_valid);
            end
        end
        reset            = 1'b0;
        req_if.req_valid = 1'b0;
        #1;
        checks++;
        if (req_if.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_if.req_ready);
        end
        checks++;
        if (mem_if.Mem_Addr !== 64'h0 || req_if.rsp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: Mem_Addr=%h rsp_rdata=%h expected 0/0",
                     mem_if.Mem_Addr, req_if.rsp_rdata);
        end
    endtask

    task automatic test_double();
        issue(1'b1, F3_D, 64'h10, 64'h0123456789ABCDEF);
        checks++;
        if (!ready_seen || lat !== 2 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL sd_resp: ready=%b lat=%0d err=%b expected 1/2/0", ready_seen, lat, r_err);
        end
        checks++;
        if (n_wr !== 1 || n_rd !== 0 || w_addr !== 64'h10 || w_data !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL sd_bus: wr=%0d rd=%0d addr=%h data=%h expected 1/0/10/0123456789abcdef",
                     n_wr, n_rd, w_addr, w_data);
        end
        checks++;
        if (extra_valid !== 1'b0 || idle_addr !== 64'h0) begin
            errors++;
            $display("FAIL sd_idle: rsp_valid=%b Mem_Addr=%h expected 0/0", extra_valid, idle_addr);
        end
        issue(1'b0, F3_D, 64'h10, 64'h0);
        checks++;
        if (lat !== 2 || r_rdata !== 64'h0123456789ABCDEF || r_err !== 1'b0) begin
            errors++;
            $display("FAIL ld_resp: lat=%0d data=%h err=%b expected 2/0123456789abcdef/0",
                     lat, r_rdata, r_err);
        end
        checks++;
        if (n_rd !== 1 || n_wr !== 0 || rd_addr !== 64'h10) begin
            errors++;
            $display("FAIL ld_bus: rd=%0d wr=%0d addr=%h expected 1/0/10", n_rd, n_wr, rd_addr);
        end
    endtask

    task automatic test_store_byte();
        issue(1'b1, F3_B, 64'h13, 64'hFF);
        checks++;
        if (lat !== 3 || n_rd !== 1 || n_wr !== 1 || both_hi !== 1'b0) begin
            errors++;
            $display("FAIL sb_seq: lat=%0d rd=%0d wr=%0d both=%b expected 3/1/1/0",
                     lat, n_rd, n_wr, both_hi);
        end
        checks++;
        if (w_addr !== 64'h10 || w_data !== 64'h01234567FFABCDEF) begin
            errors++;
            $display("FAIL sb_merge: addr=%h data=%h expected 10/01234567ffabcdef", w_addr, w_data);
        end
        checks++;
        if (r_rdata !== 64'h0) begin
            errors++;
            $display("FAIL sb_rdata: got %h expected 0", r_rdata);
        end
        issue(1'b0, F3_B, 64'h13, 64'h0);
        checks++;
        if (lat !== 2 || r_rdata !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("FAIL lb: lat=%0d data=%h expected 2/ffffffffffffffff", lat, r_rdata);
        end
        issue(1'b0, F3_BU, 64'h13, 64'h0);
        checks++;
        if (lat !== 2 || r_rdata !== 64'hFF) begin
            errors++;
            $display("FAIL lbu: lat=%0d data=%h expected 2/ff", lat, r_rdata);
        end
    endtask

    task automatic test_word_half();
        logic [2:0]  f3  [6] = '{F3_W, F3_H, F3_H, F3_HU, F3_W, F3_WU};
        logic [63:0] adr [6] = '{64'h14, 64'h16, 64'h12, 64'h12, 64'h14, 64'h14};
        logic [63:0] exp [6] = '{64'h0000000001234567, 64'h0123, 64'hFFFFFFFFFFFFFFAB,
                                 64'hFFAB, 64'hFFFFFFFF80000000, 64'h80000000};
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                issue(1'b1, F3_W, 64'h14, 64'h80000000);
                checks++;
                if (lat !== 3 || w_data !== 64'h80000000FFABCDEF) begin
                    errors++;
                    $display("FAIL sw_merge: lat=%0d data=%h expected 3/80000000ffabcdef",
                             lat, w_data);
                end
            end
            issue(1'b0, f3[i], adr[i], 64'h0);
            checks++;
            if (lat !== 2 || r_rdata !== exp[i] || r_err !== 1'b0) begin
                errors++;
                $display("FAIL load[%0d] f3=%b addr=%h: lat=%0d data=%h err=%b expected 2/%h/0",
                         i, f3[i], adr[i], lat, r_rdata, r_err, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        wr  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3  [5] = '{F3_H, F3_W, F3_D, F3_ILL, F3_BU};
        logic [63:0] adr [5] = '{64'h11, 64'h12, 64'h0C, 64'h10, 64'h10};
        for (int i = 0; i < 5; i++) begin
            issue(wr[i], f3[i], adr[i], 64'h5555555555555555);
            checks++;
            if (lat !== 1 || r_err !== 1'b1 || r_rdata !== 64'h0 || n_rd !== 0 || n_wr !== 0) begin
                errors++;
                $display("FAIL err[%0d] f3=%b addr=%h: lat=%0d err=%b data=%h rd=%0d wr=%0d expected 1/1/0/0/0",
                         i, f3[i], adr[i], lat, r_err, r_rdata, n_rd, n_wr);
            end
        end
        checks++;
        if (mem[2] !== 64'h80000000FFABCDEF || mem[1] !== 64'h0) begin
            errors++;
            $display("FAIL err_mem: mem[2]=%h mem[1]=%h expected 80000000ffabcdef/0", mem[2], mem[1]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic saw_valid = 1'b0;
        @(negedge clk);
        req_if.req_valid  = 1'b1;
        req_if.req_write  = 1'b1;
        req_if.req_funct3 = F3_B;
        req_if.req_addr   = 64'h18;
        req_if.req_wdata  = 64'hAA;
        @(negedge clk);
        // Back-to-back load offered while busy must be ignored.
        req_if.req_write  = 1'b0;
        req_if.req_funct3 = F3_D;
        req_if.req_addr   = 64'h10;
        checks++;
        if (req_if.req_ready !== 1'b0 || mem_if.MemRead !== 1'b1) begin
            errors++;
            $display("FAIL busy_read: ready=%b MemRead=%b expected 0/1", req_if.req_ready, mem_if.MemRead);
        end
        @(negedge clk);
        checks++;
        if (req_if.req_ready !== 1'b0 || mem_if.MemWrite !== 1'b1 || mem_if.Write_Data !== 64'hAA) begin
            errors++;
            $display("FAIL busy_write: ready=%b MemWrite=%b data=%h expected 0/1/aa",
                     req_if.req_ready, mem_if.MemWrite, mem_if.Write_Data);
        end
        reset            = 1'b1;
        req_if.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_if.MemWrite !== 1'b0 || req_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_write: MemWrite=%b rsp_valid=%b expected 0/0",
                     mem_if.MemWrite, req_if.rsp_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_if.rsp_valid === 1'b1 || mem_if.MemRead === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || req_if.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_drop: activity=%b ready=%b expected 0/1", saw_valid, req_if.req_ready);
        end
        issue(1'b0, F3_D, 64'h10, 64'h0);
        checks++;
        if (lat !== 2 || r_rdata !== 64'h80000000FFABCDEF) begin
            errors++;
            $display("FAIL post_rst_ld: lat=%0d data=%h expected 2/80000000ffabcdef", lat, r_rdata);
        end
    endtask

    initial begin
        req_if.req_valid  = 1'b1;
        req_if.req_write  = 1'b0;
        req_if.req_funct3 = F3_D;
        req_if.req_addr   = 64'h10;
        req_if.req_wdata  = 64'h0;
        test_reset();
        test_double();
        test_store_byte();
        test_word_half();
        test_errors();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
